tick_watchdog: RTL

Windowed watchdog driven by the periodic one-cycle `tick` from the upstream delay counter (its `sig` output, one pulse every N+1 clocks). It counts ticks between `kick` events and enforces a service window. A kick before the window opens is a violation, and so is the absence of a kick by the timeout. Either violation latches `bite` until software disarms. An internal invariant flag `err` is provided for formal checking and must never assert after reset.

---
 rtl/tick_watchdog.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tick_watchdog.sv
// ---------------------------------------------------------------------------
// tick_watchdog
//
// Windowed watchdog counting time-base ticks between service kicks. After
// arming, the block waits in CLOSED until WIN_OPEN ticks have elapsed, then
// moves to OPEN where a kick restarts the cycle. A kick while still CLOSED
// (too early) or the absence of a kick by TIMEOUT ticks latches BITE until
// software drops arm.
//
// Parameters:
//   WIN_OPEN  tick count at which the service window opens
//   TIMEOUT   tick count at which an unserviced window bites
//   TBITS     width of the tick counter
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   tick       in   one-cycle time-base pulse
//   arm        in   level, 1 enables the watchdog
//   kick       in   one-cycle service pulse
//   bite       out  1 while in BITE
//   early      out  registered one-cycle pulse on a premature kick
//   in_window  out  1 while in OPEN
//   tcnt       out  current tick count
//   err        out  invariant flag (tcnt above TIMEOUT), never 1
// ---------------------------------------------------------------------------
module tick_watchdog #(
    parameter int WIN_OPEN = 4,
    parameter int TIMEOUT  = 10,
    parameter int TBITS    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             arm,
    input  logic             kick,
    output logic             bite,
    output logic             early,
    output logic             in_window,
    output logic [TBITS-1:0] tcnt,
    output logic             err
);

    // Reject configurations where the window would never open or the
    // timeout could not be represented in the counter.
    generate
        if (!((WIN_OPEN > 0) && (WIN_OPEN < TIMEOUT) && (TBITS > 0) && (TBITS < 63) &&
              (longint'(TIMEOUT) < (longint'(1) << TBITS)))) begin : g_bad_cfg
            $error("tick_watchdog: illegal WIN_OPEN/TIMEOUT/TBITS configuration");
        end
    endgenerate

    localparam logic [1:0] DISARMED = 2'd0;
    localparam logic [1:0] CLOSED   = 2'd1;
    localparam logic [1:0] OPEN     = 2'd2;
    localparam logic [1:0] BITE     = 2'd3;

    localparam logic [TBITS-1:0] WIN_CNT  = TBITS'(WIN_OPEN);
    localparam logic [TBITS-1:0] TO_CNT   = TBITS'(TIMEOUT);
    localparam logic [TBITS-1:0] TO_LAST  = TBITS'(TIMEOUT - 1);
    localparam logic [TBITS-1:0] CNT_ONE  = TBITS'(1);

    logic [1:0]       state_q, state_d;
    logic [TBITS-1:0] tcnt_q, tcnt_d;
    logic             early_q, early_d;
    logic [TBITS-1:0] tcnt_inc;

    // The increment is only used in CLOSED/OPEN, where the TIMEOUT exit
    // keeps tcnt below TIMEOUT, so it can never wrap.
    assign tcnt_inc = tcnt_q + CNT_ONE;

    // Next-state logic. Priority inside a cycle is disarm, then kick, then
    // tick; reset is applied in the register block.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        early_d = 1'b0;
        if (!arm) begin
            state_d = DISARMED;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                DISARMED: begin
                    state_d = CLOSED;
                    tcnt_d  = '0;
                end
                CLOSED: begin
                    if (kick) begin
                        // Premature service: latch the bite, keep the count
                        // for post-mortem inspection.
                        state_d = BITE;
                        early_d = 1'b1;
                    end else if (tick) begin
                        tcnt_d = tcnt_inc;
                        if (tcnt_inc == WIN_CNT) begin
                            state_d = OPEN;
                        end
                    end
                end
                OPEN: begin
                    if (kick) begin
                        // A tick arriving with the kick is deliberately lost;
                        // the new window period starts from zero.
                        state_d = CLOSED;
                        tcnt_d  = '0;
                    end else if (tick) begin
                        tcnt_d = tcnt_inc;
                        if (tcnt_inc == TO_CNT) begin
                            state_d = BITE;
                        end
                    end
                end
                default: begin
                    // BITE holds until arm drops.
                    state_d = BITE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DISARMED;
            tcnt_q  <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            early_q <= early_d;
        end
    end

    // Outputs decode registered state only.
    assign bite      = (state_q == BITE);
    assign in_window = (state_q == OPEN);
    assign early     = early_q;
    assign tcnt      = tcnt_q;
    assign err       = (tcnt_q > TO_CNT);

    // Embedded invariants.
    a_no_err : assert property (@(posedge clk) disable iff (rst) !err);
    a_bite_not_open : assert property (@(posedge clk) disable iff (rst) bite |-> !in_window);
    a_early_bite : assert property (@(posedge clk) disable iff (rst) early |-> bite);
    a_bite_cause : assert property (@(posedge clk) disable iff (rst)
        $rose(bite) |-> ($past(state_q == CLOSED && kick) ||
                         $past(state_q == OPEN && tick && tcnt_q == TO_LAST)));

endmodule
